// File: rtl/sparc_exu_eclwbpipe_if.sv
// rtl/sparc_exu_eclwbpipe_if.sv - EXU writeback-pipe bypass producer signal bundle
// Optional RAW-check signals exist only with SPARC_EXU_WBPIPE_RAWCHK_EN.
interface sparc_exu_eclwbpipe_if;
    logic       valid_d;
    logic       wen_d;
    logic       ll_d;
    logic [4:0] rd_d;
    logic [1:0] tid_d;
    logic       hold_d;
    logic       ifu_exu_kill_e;
    logic       ll_done_g;
    logic [4:0] rd_e;
    logic [4:0] rd_m;
    logic [4:0] ecl_irf_rd_w;
    logic [1:0] tid_e;
    logic [1:0] tid_m;
    logic [1:0] ecl_irf_tid_w;
    logic       wb_e;
    logic       bypass_m;
    logic       bypass_w;
    logic       thr_match_de;
    logic       thr_match_dm;
    logic [4:0] wb_byplog_rd_w2;
    logic [1:0] wb_byplog_tid_w2;
    logic       wb_byplog_wen_w2;
    logic       ll_full;
    logic [3:0] ll_pending;
    logic       ll_ovf;
`ifdef SPARC_EXU_WBPIPE_RAWCHK_EN
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic       ll_raw_d;
`endif

    modport master (
`ifdef SPARC_EXU_WBPIPE_RAWCHK_EN
        output rs1_d, rs2_d,
        input  ll_raw_d,
`endif
        output valid_d, wen_d, ll_d, rd_d, tid_d, hold_d, ifu_exu_kill_e, ll_done_g,
        input  rd_e, rd_m, ecl_irf_rd_w, tid_e, tid_m, ecl_irf_tid_w,
        input  wb_e, bypass_m, bypass_w, thr_match_de, thr_match_dm,
        input  wb_byplog_rd_w2, wb_byplog_tid_w2, wb_byplog_wen_w2,
        input  ll_full, ll_pending, ll_ovf
    );

    modport slave (
`ifdef SPARC_EXU_WBPIPE_RAWCHK_EN
        input  rs1_d, rs2_d,
        output ll_raw_d,
`endif
        input  valid_d, wen_d, ll_d, rd_d, tid_d, hold_d, ifu_exu_kill_e, ll_done_g,
        output rd_e, rd_m, ecl_irf_rd_w, tid_e, tid_m, ecl_irf_tid_w,
        output wb_e, bypass_m, bypass_w, thr_match_de, thr_match_dm,
        output wb_byplog_rd_w2, wb_byplog_tid_w2, wb_byplog_wen_w2,
        output ll_full, ll_pending, ll_ovf
    );
endinterface

// File: rtl/sparc_exu_eclwbpipe.sv
// rtl/sparc_exu_eclwbpipe.sv - D/E/M/W destination pipe plus long-latency W2 destination queue
// Optional RAW check on queued LL destinations: define SPARC_EXU_WBPIPE_RAWCHK_EN.
module sparc_exu_eclwbpipe #(
    parameter int LL_DEPTH = 4,
    parameter int LL_CW    = 3
) (
    input logic                  rclk,
    input logic                  reset,
    sparc_exu_eclwbpipe_if.slave bus
);
    localparam int PW = $clog2(LL_DEPTH);

    logic             r_valid_e, r_wen_e, r_ll_e;
    logic [4:0]       r_rd_e, r_rd_m, r_rd_w;
    logic [1:0]       r_tid_e, r_tid_m, r_tid_w;
    logic             r_bypass_m, r_bypass_w;

    logic [4:0]       r_q_rd  [LL_DEPTH];
    logic [1:0]       r_q_tid [LL_DEPTH];
    logic [LL_DEPTH-1:0] r_q_vld;
    logic [PW-1:0]    r_wp, r_rp;
    logic [LL_CW-1:0] r_cnt;
    logic             r_full, r_ovf;
    logic [4:0]       r_w2_rd;
    logic [1:0]       r_w2_tid;
    logic             r_w2_wen;

    logic             w_wb_e, w_push, w_pop, w_push_ok;
    logic [LL_CW-1:0] w_cnt_nxt;
    logic [3:0]       w_pend;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(LL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_wb_e    = r_valid_e & r_wen_e & ~r_ll_e;
    assign w_push    = r_valid_e & r_ll_e & r_wen_e & ~bus.ifu_exu_kill_e;
    // An empty queue never pops, so a push into it is never bypassed straight to W2.
    assign w_pop     = bus.ll_done_g & (r_cnt != '0);
    assign w_push_ok = w_push & (~r_full | w_pop);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push_ok && !w_pop)
            w_cnt_nxt = r_cnt + 1'b1;
        else if (w_pop && !w_push_ok)
            w_cnt_nxt = r_cnt - 1'b1;
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_valid_e  <= 1'b0;
            r_wen_e    <= 1'b0;
            r_ll_e     <= 1'b0;
            r_rd_e     <= '0;
            r_tid_e    <= '0;
            r_bypass_m <= 1'b0;
            r_rd_m     <= '0;
            r_tid_m    <= '0;
            r_bypass_w <= 1'b0;
            r_rd_w     <= '0;
            r_tid_w    <= '0;
        end else begin
            r_valid_e <= bus.valid_d & ~bus.hold_d;
            if (!bus.hold_d) begin
                r_wen_e <= bus.wen_d;
                r_ll_e  <= bus.ll_d;
                r_rd_e  <= bus.rd_d;
                r_tid_e <= bus.tid_d;
            end
            r_bypass_m <= w_wb_e & ~bus.ifu_exu_kill_e;
            r_rd_m     <= r_rd_e;
            r_tid_m    <= r_tid_e;
            r_bypass_w <= r_bypass_m;
            r_rd_w     <= r_rd_m;
            r_tid_w    <= r_tid_m;
        end
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LL_DEPTH; i++) begin
                r_q_rd[i]  <= '0;
                r_q_tid[i] <= '0;
            end
            r_q_vld  <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_w2_rd  <= '0;
            r_w2_tid <= '0;
            r_w2_wen <= 1'b0;
        end else begin
            r_w2_wen <= w_pop;
            if (w_pop) begin
                r_w2_rd        <= r_q_rd[r_rp];
                r_w2_tid       <= r_q_tid[r_rp];
                r_q_vld[r_rp]  <= 1'b0;
                r_rp           <= f_inc(r_rp);
            end
            // Placed after the pop so a full-queue push+pop on the same slot leaves it valid.
            if (w_push_ok) begin
                r_q_rd[r_wp]  <= r_rd_e;
                r_q_tid[r_wp] <= r_tid_e;
                r_q_vld[r_wp] <= 1'b1;
                r_wp          <= f_inc(r_wp);
            end
            if (w_push && !w_push_ok)
                r_ovf <= 1'b1;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == LL_CW'(LL_DEPTH));
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < LL_DEPTH; i++)
            if (r_q_vld[i])
                w_pend[r_q_tid[i]] = 1'b1;
    end

`ifdef SPARC_EXU_WBPIPE_RAWCHK_EN
    logic w_raw;

    function automatic logic f_hit(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return ((rs1 != '0) && (rs1 == rd)) || ((rs2 != '0) && (rs2 == rd));
    endfunction

    always_comb begin
        w_raw = 1'b0;
        for (int i = 0; i < LL_DEPTH; i++)
            if (r_q_vld[i] && (r_q_tid[i] == bus.tid_d))
                w_raw = w_raw | f_hit(r_q_rd[i], bus.rs1_d, bus.rs2_d);
        if (w_push && (r_tid_e == bus.tid_d))
            w_raw = w_raw | f_hit(r_rd_e, bus.rs1_d, bus.rs2_d);
    end

    assign bus.ll_raw_d = bus.valid_d & w_raw;
`endif

    assign bus.rd_e             = r_rd_e;
    assign bus.tid_e            = r_tid_e;
    assign bus.rd_m             = r_rd_m;
    assign bus.tid_m            = r_tid_m;
    assign bus.ecl_irf_rd_w     = r_rd_w;
    assign bus.ecl_irf_tid_w    = r_tid_w;
    assign bus.wb_e             = w_wb_e;
    assign bus.bypass_m         = r_bypass_m;
    assign bus.bypass_w         = r_bypass_w;
    assign bus.thr_match_de     = (bus.tid_d == r_tid_e);
    assign bus.thr_match_dm     = (bus.tid_d == r_tid_m);
    assign bus.wb_byplog_rd_w2  = r_w2_rd;
    assign bus.wb_byplog_tid_w2 = r_w2_tid;
    assign bus.wb_byplog_wen_w2 = r_w2_wen;
    assign bus.ll_full          = r_full;
    assign bus.ll_pending       = w_pend;
    assign bus.ll_ovf           = r_ovf;
endmodule

// File: tb/tb_sparc_exu_eclwbpipe.sv
// tb/tb_sparc_exu_eclwbpipe.sv - directed self-checking bench for sparc_exu_eclwbpipe
module tb_sparc_exu_eclwbpipe;
    logic rclk;
    logic reset;
    int   n_pass;
    int   n_total;

    sparc_exu_eclwbpipe_if bus ();

    sparc_exu_eclwbpipe #(.LL_DEPTH(4), .LL_CW(3)) dut (
        .rclk  (rclk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge rclk);
        #1;
    endtask

    task automatic idle;
        bus.valid_d        = 1'b0;
        bus.wen_d          = 1'b0;
        bus.ll_d           = 1'b0;
        bus.rd_d           = 5'd0;
        bus.tid_d          = 2'd0;
        bus.hold_d         = 1'b0;
        bus.ifu_exu_kill_e = 1'b0;
        bus.ll_done_g      = 1'b0;
`ifdef SPARC_EXU_WBPIPE_RAWCHK_EN
        bus.rs1_d          = 5'd0;
        bus.rs2_d          = 5'd0;
`endif
    endtask

    task automatic issue(input logic ll, input logic [4:0] rd, input logic [1:0] tid);
        bus.valid_d = 1'b1;
        bus.wen_d   = 1'b1;
        bus.ll_d    = ll;
        bus.rd_d    = rd;
        bus.tid_d   = tid;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle();
        reset = 1'b1;
        step();
        step();
        chk("rst_rd_e", bus.rd_e, 0);
        chk("rst_wb_e", bus.wb_e, 0);
        chk("rst_pend", bus.ll_pending, 0);
        chk("rst_full", bus.ll_full, 0);
        chk("rst_ovf", bus.ll_ovf, 0);
        chk("rst_wen_w2", bus.wb_byplog_wen_w2, 0);
        reset = 1'b0;

        // ALU op through E, M, W
        issue(1'b0, 5'd5, 2'd2);
        step();
        chk("alu_wb_e", bus.wb_e, 1);
        chk("alu_rd_e", bus.rd_e, 5);
        chk("alu_thr_de", bus.thr_match_de, 1);
        bus.tid_d = 2'd1;
        #1;
        chk("alu_thr_de_no", bus.thr_match_de, 0);
        idle();
        bus.tid_d = 2'd2;
        step();
        chk("alu_byp_m", bus.bypass_m, 1);
        chk("alu_rd_m", bus.rd_m, 5);
        chk("alu_tid_m", bus.tid_m, 2);
        chk("alu_thr_dm", bus.thr_match_dm, 1);
        chk("alu_wb_e_idle", bus.wb_e, 0);
        idle();
        step();
        chk("alu_byp_w", bus.bypass_w, 1);
        chk("alu_rd_w", bus.ecl_irf_rd_w, 5);
        chk("alu_tid_w", bus.ecl_irf_tid_w, 2);

        // killed ALU op: wb_e still high, no bypass downstream
        issue(1'b0, 5'd6, 2'd0);
        step();
        chk("kill_wb_e", bus.wb_e, 1);
        idle();
        bus.ifu_exu_kill_e = 1'b1;
        step();
        bus.ifu_exu_kill_e = 1'b0;
        chk("kill_byp_m", bus.bypass_m, 0);
        chk("kill_rd_m", bus.rd_m, 6);
        step();
        chk("kill_byp_w", bus.bypass_w, 0);

        // hold inserts a bubble and keeps rd/tid
        issue(1'b0, 5'd7, 2'd1);
        step();
        bus.hold_d = 1'b1;
        bus.rd_d   = 5'd3;
        bus.tid_d  = 2'd3;
        step();
        chk("hold_wb_e", bus.wb_e, 0);
        chk("hold_rd_e", bus.rd_e, 7);
        chk("hold_tid_e", bus.tid_e, 1);
        idle();
        step();

        // two LL ops, in-order W2 return
        issue(1'b1, 5'd9, 2'd1);
        step();
        chk("ll_wb_e", bus.wb_e, 0);
        issue(1'b1, 5'd12, 2'd3);
        step();
        chk("ll_pend1", bus.ll_pending, 4'b0010);
        idle();
        step();
        chk("ll_pend2", bus.ll_pending, 4'b1010);
        bus.ll_done_g = 1'b1;
        step();
        chk("ll_w2_wen_a", bus.wb_byplog_wen_w2, 1);
        chk("ll_w2_rd_a", bus.wb_byplog_rd_w2, 9);
        chk("ll_w2_tid_a", bus.wb_byplog_tid_w2, 1);
        chk("ll_pend3", bus.ll_pending, 4'b1000);
        step();
        chk("ll_w2_wen_b", bus.wb_byplog_wen_w2, 1);
        chk("ll_w2_rd_b", bus.wb_byplog_rd_w2, 12);
        chk("ll_w2_tid_b", bus.wb_byplog_tid_w2, 3);
        chk("ll_pend4", bus.ll_pending, 0);
        step();
        chk("ll_done_empty_wen", bus.wb_byplog_wen_w2, 0);
        chk("ll_done_empty_rd", bus.wb_byplog_rd_w2, 12);
        bus.ll_done_g = 1'b0;

        // fill, push+pop while full, overflow
        issue(1'b1, 5'd1, 2'd0);
        step();
        for (int r = 2; r <= 5; r++) begin
            bus.rd_d = 5'(r);
            step();
        end
        chk("full_set", bus.ll_full, 1);
        chk("full_pend", bus.ll_pending, 4'b0001);
        bus.rd_d      = 5'd6;
        bus.ll_done_g = 1'b1;
        step();
        chk("full_pp_full", bus.ll_full, 1);
        chk("full_pp_ovf", bus.ll_ovf, 0);
        chk("full_pp_w2", bus.wb_byplog_rd_w2, 1);
        idle();
        step();
        chk("ovf_set", bus.ll_ovf, 1);
        chk("ovf_full", bus.ll_full, 1);
        step();
        chk("ovf_sticky", bus.ll_ovf, 1);
        bus.ll_done_g = 1'b1;
        for (int r = 2; r <= 5; r++) begin
            step();
            chk("drain_wen", bus.wb_byplog_wen_w2, 1);
            chk("drain_rd", bus.wb_byplog_rd_w2, 32'(r));
        end
        chk("drain_full", bus.ll_full, 0);
        step();
        chk("drain_done_wen", bus.wb_byplog_wen_w2, 0);
        chk("drain_done_rd", bus.wb_byplog_rd_w2, 5);
        chk("drain_pend", bus.ll_pending, 0);
        bus.ll_done_g = 1'b0;

        // push into empty queue with ll_done_g: pop ignored, entry kept
        issue(1'b1, 5'd20, 2'd2);
        step();
        idle();
        bus.ll_done_g = 1'b1;
        step();
        bus.ll_done_g = 1'b0;
        chk("pe_wen", bus.wb_byplog_wen_w2, 0);
        chk("pe_pend", bus.ll_pending, 4'b0100);
`ifdef SPARC_EXU_WBPIPE_RAWCHK_EN
        bus.valid_d = 1'b1;
        bus.tid_d   = 2'd2;
        bus.rs1_d   = 5'd20;
        #1;
        chk("raw_hit", bus.ll_raw_d, 1);
        bus.tid_d = 2'd1;
        #1;
        chk("raw_tid", bus.ll_raw_d, 0);
        bus.tid_d = 2'd2;
        bus.rs1_d = 5'd0;
        #1;
        chk("raw_rs0", bus.ll_raw_d, 0);
        bus.rs2_d = 5'd20;
        #1;
        chk("raw_rs2", bus.ll_raw_d, 1);
        idle();
`endif
        bus.ll_done_g = 1'b1;
        step();
        bus.ll_done_g = 1'b0;
        chk("pe_pop_rd", bus.wb_byplog_rd_w2, 20);
        chk("pe_pop_tid", bus.wb_byplog_tid_w2, 2);

        // asynchronous reset with two queued LL entries and a live ALU op
        issue(1'b1, 5'd10, 2'd0);
        step();
        bus.rd_d  = 5'd11;
        bus.tid_d = 2'd2;
        step();
        issue(1'b0, 5'd13, 2'd1);
        step();
        chk("mid_pend", bus.ll_pending, 4'b0101);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pend", bus.ll_pending, 0);
        chk("mid_rst_wb_e", bus.wb_e, 0);
        chk("mid_rst_rd_e", bus.rd_e, 0);
        chk("mid_rst_byp_m", bus.bypass_m, 0);
        chk("mid_rst_ovf", bus.ll_ovf, 0);
        idle();
        step();
        reset = 1'b0;
        bus.ll_done_g = 1'b1;
        step();
        chk("mid_rst_no_w2", bus.wb_byplog_wen_w2, 0);
        step();
        chk("mid_rst_no_w2b", bus.wb_byplog_wen_w2, 0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sparc_exu_eclwbpipe.md
Name: sparc_exu_eclwbpipe

Overview:
- Producer side of the EXU operand-bypass interface.
- Carries destination register, thread ID and write-enable from D through E, M and W, and drives the rd/tid/wen/bypass qualifiers that per-operand bypass selectors consume.
- Holds an in-order queue of long-latency (mul/div) destinations and drives the dedicated W2 writeback/bypass slot when each result returns.
- Sits in the EXU control block, between IFU decode and the integer register file write ports.

Parameters:
- LL_DEPTH, 4, long-latency destination queue entries (legal 2..8).
- LL_CW, 3, queue occupancy counter width; must hold the value LL_DEPTH.

Ports:
- rclk  in  1  clock
- reset  in  1  asynchronous reset, active high
- valid_d  in  1  valid instruction in D
- wen_d  in  1  D instruction writes the RF
- ll_d  in  1  D instruction is long-latency (mul/div)
- rd_d  in  5  D destination register
- tid_d  in  2  D thread
- hold_d  in  1  D held; E receives a bubble
- ifu_exu_kill_e  in  1  kill the instruction in E
- ll_done_g  in  1  long-latency result ready for the queue head
- rd_e, rd_m, ecl_irf_rd_w  out  5 each  stage destinations
- tid_e, tid_m, ecl_irf_tid_w  out  2 each  stage threads
- wb_e  out  1  E writes the RF (non-LL, valid)
- bypass_m, bypass_w  out  1 each  M/W results are bypassable
- thr_match_de, thr_match_dm  out  1 each  tid_d==tid_e / tid_d==tid_m (combinational)
- wb_byplog_rd_w2  out  5  W2 destination
- wb_byplog_tid_w2  out  2  W2 thread
- wb_byplog_wen_w2  out  1  W2 write valid
- ll_full  out  1  queue full; IFU must not issue LL
- ll_pending  out  4  per-thread: at least one LL entry outstanding
- ll_ovf  out  1  sticky overflow error

Behaviour:
- Reset (asynchronous, active high): every output register goes to 0; queue becomes empty; ll_ovf=0.
- D->E on each rclk edge:
  - If ~hold_d: E takes valid_d, wen_d, ll_d, rd_d, tid_d.
  - If hold_d: E valid=0 (bubble); rd/tid hold their values.
- wb_e = valid_e & wen_e & ~ll_e. It is not qualified by kill; consumers apply kill themselves.
- E->M: bypass_m <= wb_e & ~ifu_exu_kill_e. rd_m and tid_m follow rd_e and tid_e.
- M->W: bypass_w <= bypass_m. ecl_irf_rd_w and ecl_irf_tid_w follow rd_m and tid_m.
- Latency: 1 cycle per stage. Never stalls beyond D.
- Queue push: at the end of a cycle with valid_e & ll_e & wen_e & ~ifu_exu_kill_e, push {tid_e, rd_e} at the tail.
- Queue pop: when ll_done_g and the queue is non-empty.
  - The next cycle drives wb_byplog_wen_w2=1 with the head's rd and tid.
  - Otherwise wb_byplog_wen_w2=0 and rd/tid hold their last values.
- Push and pop in the same cycle: both occur and the count is unchanged, including when full.
- Push while empty with ll_done_g: the pop is ignored and the push is kept (no same-cycle pass-through).
- ll_done_g while empty: ignored.
- Push while full without a pop: the entry is dropped and ll_ovf sets; ll_ovf is cleared only by reset.
- ll_full = (count==LL_DEPTH), registered.
- ll_pending[t] = OR over valid entries whose tid==t, from registered state.
- Read and write pointers wrap modulo LL_DEPTH. Ordering is strictly FIFO.
- Reset mid-operation discards queued entries; no W2 write occurs afterwards.

Optional Feature:
- SPARC_EXU_WBPIPE_RAWCHK_EN
- When defined, adds inputs rs1_d[4:0], rs2_d[4:0] and output ll_raw_d.
- ll_raw_d = valid_d & OR over valid queue entries of (entry.tid==tid_d & rsX_d!=0 & entry.rd==rsX_d), computed combinationally from registered state.
- Also counts a matching instruction in E that will push this cycle.
- When undefined, these ports are absent and there is no comparator logic.

Test Plan:
- Reset mid-run with 2 LL entries queued and valid stages → all outputs 0, ll_pending=0; a later ll_done_g produces no W2 write.
- ALU op rd=5, tid=2, wen=1 in D, no hold/kill → wb_e=1 in cycle 1, bypass_m=1/rd_m=5 in cycle 2, bypass_w=1/ecl_irf_rd_w=5/tid_w=2 in cycle 3.
- Same op with ifu_exu_kill_e=1 in E → wb_e=1 in E, but bypass_m=0 and bypass_w=0.
- Issue LL rd=9/tid=1, then rd=12/tid=3; pulse ll_done_g twice → W2 outputs (9,1) then (12,3), each with wen_w2=1; ll_pending goes 0b1010→0b1000→0.
- Fill 4 entries → ll_full=1. Push with ll_done_g the same cycle → count stays 4, no ovf. Push with no done → ll_ovf=1 and sticks.
- RAWCHK_EN: queue holds (tid0, rd7); D has tid0, rs1=7 → ll_raw_d=1. Same with tid1, or with rs1=0 → ll_raw_d=0.
